// File: rtl/uart_tx_fifo_if.sv
// Producer-side byte handshake and status bundle for uart_tx_fifo.
// The producer (master) drives din/wr_en and watches the FIFO and line status.
interface uart_tx_fifo_if;
    logic [7:0] din;
    logic       wr_en;
    logic       full;
    logic       empty;
    logic       busy;
    logic       tx_done;

    modport master (
        output din,
        output wr_en,
        input  full,
        input  empty,
        input  busy,
        input  tx_done
    );

    modport slave (
        input  din,
        input  wr_en,
        output full,
        output empty,
        output busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serializer, LSB first.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 frames).
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_fifo_if.slave bus,
    output logic          tx
);

    localparam int DIVISOR = CLK_FREQ / BAUD;
    localparam int TIMER_W = $clog2(DIVISOR);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam logic [TIMER_W-1:0] BIT_LAST = TIMER_W'(DIVISOR - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               tx_done_q, tx_done_d;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic               push;
    logic               pop;
    logic               bit_end;
`ifdef UART_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    // FIFO bookkeeping; flags come from the next count so they are registered
    always_comb begin
        push     = bus.wr_en && !full_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        full_d   = (count_d == CNT_W'(FIFO_DEPTH));
        empty_d  = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            tx_done_q <= tx_done_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
        parity_q <= parity_d;
`endif
    end

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        bit_end   = (timer_q == BIT_LAST);
        timer_d   = (state_q == S_IDLE) ? '0 : timer_q + TIMER_W'(1);
        if (bit_end) begin
            timer_d = '0;
        end
        case (state_q)
            S_IDLE: begin
                if (!empty_q) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Chain straight into the next start bit when more data waits
                if (bit_end) begin
                    if (!empty_q) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef UART_TX_PARITY_EN
    always_comb begin
        parity_d = pop ? ^mem_q[rd_ptr_q] : parity_q;
    end
`endif

    // Outputs are registered from the next state so tx lines up with state_q
    always_comb begin
        tx_d      = 1'b1;
        busy_d    = (state_d != S_IDLE);
        tx_done_d = (state_d == S_STOP) && (timer_d == BIT_LAST);
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_q;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx          = tx_q;
    assign bus.full    = full_q;
    assign bus.empty   = empty_q;
    assign bus.busy    = busy_q;
    assign bus.tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-position reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_uart_tx_fifo;

    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int DEPTH    = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * DIV;

    logic clk = 1'b0;
    logic reset;
    logic tx;
    uart_tx_fifo_if bus ();

    uart_tx_fifo #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .tx   (tx)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Reference model: the line is either idle or at some cycle offset in a frame
    logic [7:0] mq[$];
    logic [7:0] cur = 8'h00;
    int         pos = -1;
    bit         model_ok = 0;

    function automatic logic fbit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        int pre;
        cyc++;
        if (reset) begin
            mq.delete();
            pos = -1;
            model_ok = 1;
        end else if (model_ok) begin
            pre = mq.size();
            if (pos >= 0) begin
                pos++;
                if (pos == FRAME_CYC) pos = -1;
            end
            if (pos < 0 && pre > 0) begin
                cur = mq.pop_front();
                pos = 0;
            end
            if (bus.wr_en && pre < DEPTH) mq.push_back(bus.din);
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("tx",      {31'd0, tx},          {31'd0, (pos < 0) ? 1'b1 : fbit(cur, pos / DIV)});
            check("busy",    {31'd0, bus.busy},    {31'd0, pos >= 0});
            check("tx_done", {31'd0, bus.tx_done}, {31'd0, pos == FRAME_CYC - 1});
            check("empty",   {31'd0, bus.empty},   {31'd0, mq.size() == 0});
            check("full",    {31'd0, bus.full},    {31'd0, mq.size() == DEPTH});
            if (bus.tx_done) done_cnt++;
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wr(input logic [7:0] b);
        bus.din   = b;
        bus.wr_en = 1'b1;
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_done(input string name, output int at);
        bit seen = 0;
        at = -1;
        for (int i = 0; i < 2 * FRAME_CYC; i++) begin
            step();
            if (bus.tx_done) begin
                seen = 1;
                at = cyc;
                break;
            end
        end
        if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    int start_c, done_c, d0;
    logic [10:0] exp_bits;
    logic [10:0] got_bits;

    initial begin
        reset = 1'b1;
        bus.din = 8'h00;
        bus.wr_en = 1'b0;

        // Idle after reset
        step(3);
        reset = 1'b0;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_empty", {31'd0, bus.empty}, 32'd1);
        step(100);
        check("idle_busy", {31'd0, bus.busy}, 32'd0);
        check("idle_full", {31'd0, bus.full}, 32'd0);

        // Single byte 0x41
        d0 = done_cnt;
        wr(8'h41);
        check("single_empty_after_write", {31'd0, bus.empty}, 32'd0);
        check("single_tx_before_start", {31'd0, tx}, 32'd1);
        step();
        check("single_tx_start", {31'd0, tx}, 32'd0);
        start_c = cyc;
`ifdef UART_TX_PARITY_EN
        exp_bits = 11'b10010000010;
`else
        exp_bits = 11'b00_1010000010;
`endif
        got_bits = '0;
        step(DIV / 2);
        for (int k = 0; k < FRAME_BITS; k++) begin
            got_bits[k] = tx;
            if (k < FRAME_BITS - 1) step(DIV);
        end
        check("single_bits", {21'd0, got_bits}, {21'd0, exp_bits});
        wait_done("single_done", done_c);
        check("single_frame_len", done_c - start_c, FRAME_CYC - 1);
        step();
        check("single_busy_after", {31'd0, bus.busy}, 32'd0);
        check("single_done_count", done_cnt - d0, 32'd1);

        // Back-to-back 0x55, 0xAA, 0x0D
        step(5);
        d0 = done_cnt;
        wr(8'h55);
        wr(8'hAA);
        start_c = cyc;
        wr(8'h0D);
        for (int k = 0; k < 3; k++) wait_done("b2b_done", done_c);
        check("b2b_span", done_c - start_c, 3 * FRAME_CYC - 1);
        step();
        check("b2b_busy_after", {31'd0, bus.busy}, 32'd0);
        check("b2b_done_count", done_cnt - d0, 32'd3);

        // Overflow with depth 4
        step(5);
        d0 = done_cnt;
        for (int k = 0; k < 8; k++) wr(8'h30 + 8'(k));
        check("ovf_full", {31'd0, bus.full}, 32'd1);
        for (int k = 0; k < 5; k++) wait_done("ovf_done", done_c);
        step();
        check("ovf_busy_after", {31'd0, bus.busy}, 32'd0);
        step(2 * FRAME_CYC);
        check("ovf_frames", done_cnt - d0, 32'd5);

        // Reset during data bit 3 of 0x7E with two bytes queued
        step(5);
        wr(8'h7E);
        wr(8'h11);
        wr(8'h22);
        step(4 * DIV + DIV / 2 - 1);
        check("rst_mid_bit3", {31'd0, tx}, 32'd1);
        check("rst_mid_busy", {31'd0, bus.busy}, 32'd1);
        d0 = done_cnt;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_tx", {31'd0, tx}, 32'd1);
        check("rst_mid_empty", {31'd0, bus.empty}, 32'd1);
        check("rst_mid_busy_after", {31'd0, bus.busy}, 32'd0);
        step(3 * FRAME_CYC);
        check("rst_mid_no_done", done_cnt - d0, 32'd0);

`ifdef UART_TX_PARITY_EN
        // Even parity: 0x07 -> 1, 0x03 -> 0
        wr(8'h07);
        step();
        start_c = cyc;
        step(9 * DIV + DIV / 2);
        check("par_07", {31'd0, tx}, 32'd1);
        wait_done("par_done", done_c);
        check("par_frame_len", done_c - start_c, 32'd109);
        step(3);
        wr(8'h03);
        step();
        step(9 * DIV + DIV / 2);
        check("par_03", {31'd0, tx}, 32'd0);
        wait_done("par_done2", done_c);
        step(3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
